// File: rtl/obi_wb_pkg.sv
// Shared types and constants for the OBI-to-Wishbone bridge.
// The FSM state encoding and the captured request record live here.
package obi_wb_pkg;

  localparam int unsigned ObiWbTimeoutDefault = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } obi_wb_state_e;

  // One OBI request as captured at grant time; it drives the Wishbone side.
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obi_wb_req_t;

endpackage : obi_wb_pkg

// File: rtl/obi_wb_bridge.sv
// Single-outstanding bridge from the core's OBI req/gnt/rvalid port to a
// Wishbone B4 classic master, with a bus timeout that forces an error response.
module obi_wb_bridge
  import obi_wb_pkg::*;
#(
  parameter int unsigned TimeoutCycles = ObiWbTimeoutDefault,
  parameter int unsigned TimeoutW      = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  // OBI side
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  // Wishbone side
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  output logic        timeout_o
);

  localparam bit                TimeoutEn   = (TimeoutCycles != 0);
  localparam logic [TimeoutW-1:0] TimeoutLast =
    TimeoutEn ? TimeoutW'(TimeoutCycles - 1) : '0;

  obi_wb_state_e       state_q;
  obi_wb_req_t         req_q;
  logic                cyc_q;
  logic [TimeoutW-1:0] cnt_q;
  logic                rvalid_q;
  logic [31:0]         rdata_q;
  logic                err_q;

  logic in_bus;
  logic bus_err;
  logic bus_ack;
  logic bus_timeout;
  logic bus_done;

  // Termination decode; error beats ack, and ack/err beat the timeout.
  always_comb begin
    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    in_bus      = (state_q == BUS);
    bus_err     = in_bus && wbm_err_i;
    bus_ack     = in_bus && wbm_ack_i && !wbm_err_i;
    bus_timeout = 1'b0;
    if (TimeoutEn) begin
      bus_timeout = in_bus && !wbm_ack_i && !wbm_err_i && (cnt_q == TimeoutLast);
    end
    bus_done    = bus_err || bus_ack || bus_timeout;
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      req_q    <= '0;
      cyc_q    <= 1'b0;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          rvalid_q <= 1'b0;
          if (req_i) begin
            req_q.addr  <= addr_i;
            req_q.we    <= we_i;
            req_q.be    <= be_i;
            req_q.wdata <= wdata_i;
            cnt_q       <= '0;
            cyc_q       <= 1'b1;
            state_q     <= BUS;
          end
        end

        BUS: begin
          cnt_q <= cnt_q + 1'b1;
          if (bus_done) begin
            cyc_q    <= 1'b0;
            rvalid_q <= 1'b1;
            err_q    <= bus_err || bus_timeout;
            // Reads return slave data only on a clean ack; writes and errors return 0.
            rdata_q  <= (bus_ack && !req_q.we) ? wbm_dat_i : 32'h0;
            state_q  <= RESP;
          end
        end

        RESP: begin
          rvalid_q <= 1'b0;
          state_q  <= IDLE;
        end

        default: begin
          cyc_q    <= 1'b0;
          rvalid_q <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  // Grant is the only combinational request path; it is masked during reset.
  assign gnt_o     = req_i && (state_q == IDLE) && !rst_i;
  assign timeout_o = bus_timeout;

  assign rvalid_o  = rvalid_q;
  assign rdata_o   = rdata_q;
  assign err_o     = err_q;

  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = req_q.we;
  assign wbm_sel_o = req_q.be;
  assign wbm_adr_o = req_q.addr;
  assign wbm_dat_o = req_q.wdata;

endmodule : obi_wb_bridge

// File: tb/tb_obi_wb_bridge.sv
// Self-checking bench for obi_wb_bridge: directed scenarios plus randomized
// transactions scored against a cycle-count reference model.
module tb_obi_wb_bridge;

  localparam int N = 255;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_i;
  logic        gnt_o;
  logic [31:0] addr_i;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] wdata_i;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;
  logic        wbm_err_i;
  logic        timeout_o;

  int tests_run    = 0;
  int tests_failed = 0;

  obi_wb_bridge #(.TimeoutCycles(N), .TimeoutW(8)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (req_i),
    .gnt_o     (gnt_o),
    .addr_i    (addr_i),
    .we_i      (we_i),
    .be_i      (be_i),
    .wdata_i   (wdata_i),
    .rvalid_o  (rvalid_o),
    .rdata_o   (rdata_o),
    .err_o     (err_o),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_sel_o (wbm_sel_o),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_dat_i (wbm_dat_i),
    .wbm_ack_i (wbm_ack_i),
    .wbm_err_i (wbm_err_i),
    .timeout_o (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: the slave answers in cycle resp_cycle (0 = never);
  // the bridge ends in cycle k = resp_cycle, or N if the slave is later or silent.
  function automatic int model_k(input int resp_cycle);
    return (resp_cycle == 0 || resp_cycle > N) ? N : resp_cycle;
  endfunction

  function automatic bit model_timed_out(input int resp_cycle);
    return (resp_cycle == 0 || resp_cycle > N);
  endfunction

  // kind: 0 = ack, 1 = err, 2 = ack and err together.
  // All stimulus changes and samples happen at the falling edge.
  task automatic run_txn(input string name, input logic [31:0] a, input logic w,
                         input logic [3:0] b, input logic [31:0] d,
                         input int resp_cycle, input int kind,
                         input logic [31:0] rd, input bit hold_req);
    int          k;
    bit          timed;
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic [73:0] exp_bus;
    k         = model_k(resp_cycle);
    timed     = model_timed_out(resp_cycle);
    exp_err   = timed || (kind != 0);
    exp_rdata = (exp_err || w) ? 32'h0 : rd;
    exp_bus   = {1'b1, 1'b1, w, b, a, d};

    // Cycle 0: request, combinational grant
    @(negedge clk_i);
    req_i = 1'b1; addr_i = a; we_i = w; be_i = b; wdata_i = d;
    wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
    #1;
    tests_run++;
    if (gnt_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s grant: got %b want 1", name, gnt_o);
    end

    for (int c = 1; c <= k; c++) begin
      @(negedge clk_i);
      req_i   = hold_req;
      addr_i  = $urandom; we_i = ~w; be_i = ~b; wdata_i = $urandom;
      if (c == resp_cycle) begin
        wbm_ack_i = (kind != 1);
        wbm_err_i = (kind != 0);
        wbm_dat_i = rd;
      end else begin
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        wbm_dat_i = $urandom;
      end
      #1;
      tests_run++;
      if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o} !== exp_bus) begin
        tests_failed++;
        $display("FAIL %s bus cycle %0d: cyc=%b stb=%b we=%b sel=%h adr=%h dat=%h want we=%b sel=%h adr=%h dat=%h",
                 name, c, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o, w, b, a, d);
      end
      tests_run++;
      if ({gnt_o, rvalid_o, timeout_o} !== {1'b0, 1'b0, (timed && c == k)}) begin
        tests_failed++;
        $display("FAIL %s ctrl cycle %0d: gnt=%b rvalid=%b timeout=%b want timeout=%b",
                 name, c, gnt_o, rvalid_o, timeout_o, (timed && c == k));
      end
    end

    // Cycle k+1: response
    @(negedge clk_i);
    wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
    #1;
    tests_run++;
    if ({rvalid_o, err_o, rdata_o} !== {1'b1, exp_err, exp_rdata}) begin
      tests_failed++;
      $display("FAIL %s response: rvalid=%b err=%b rdata=%h want rvalid=1 err=%b rdata=%h",
               name, rvalid_o, err_o, rdata_o, exp_err, exp_rdata);
    end
    tests_run++;
    if ({wbm_cyc_o, wbm_stb_o, gnt_o, timeout_o} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL %s resp ctrl: cyc=%b stb=%b gnt=%b timeout=%b want 0000",
               name, wbm_cyc_o, wbm_stb_o, gnt_o, timeout_o);
    end
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    rst_i = 1'b1; req_i = 1'b1; addr_i = 32'h1234_5678; we_i = 1'b1; be_i = 4'hF;
    wdata_i = 32'hFFFF_FFFF; wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_dat_i = '0;
    repeat (3) @(negedge clk_i);
    #1;
    tests_run++;
    if ({gnt_o, rvalid_o, rdata_o, err_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o,
         wbm_adr_o, wbm_dat_o, timeout_o} !== '0) begin
      tests_failed++;
      $display("FAIL reset outputs: gnt=%b rvalid=%b cyc=%b adr=%h dat=%h want all 0",
               gnt_o, rvalid_o, wbm_cyc_o, wbm_adr_o, wbm_dat_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0; req_i = 1'b0;
  endtask

  task automatic test_stray_ack();
    @(negedge clk_i);
    wbm_ack_i = 1'b1; wbm_err_i = 1'b1; wbm_dat_i = 32'hCAFE_F00D;
    @(negedge clk_i);
    wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
    #1;
    tests_run++;
    if ({rvalid_o, wbm_cyc_o} !== 2'b00) begin
      tests_failed++;
      $display("FAIL stray_ack: rvalid=%b cyc=%b want 00", rvalid_o, wbm_cyc_o);
    end
  endtask

  task automatic test_read_zero_wait();
    run_txn("read_zero_wait", 32'h1000_0004, 1'b0, 4'b1111, 32'h0, 1, 0, 32'hDEAD_BEEF, 1'b0);
  endtask

  task automatic test_write_wait();
    run_txn("write_wait3", 32'h3000_0010, 1'b1, 4'b0011, 32'h0000_ABCD, 4, 0, 32'h5555_AAAA, 1'b0);
  endtask

  task automatic test_ack_err_same();
    run_txn("ack_err_same", 32'h2000_0000, 1'b0, 4'b0101, 32'h0, 2, 2, 32'h1234_5678, 1'b0);
  endtask

  task automatic test_timeout();
    run_txn("timeout", 32'h4000_0000, 1'b0, 4'b1111, 32'h0, 0, 0, 32'h0, 1'b0);
    run_txn("after_timeout", 32'h4000_0008, 1'b0, 4'b1100, 32'h0, 1, 0, 32'h0BAD_F00D, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_txn("b2b_first",  32'h5000_0000, 1'b0, 4'b1111, 32'h0,          1, 0, 32'h1111_1111, 1'b1);
    run_txn("b2b_second", 32'h5000_0004, 1'b1, 4'b1111, 32'h2222_2222, 2, 0, 32'h0,          1'b1);
    run_txn("b2b_third",  32'h5000_0008, 1'b0, 4'b0001, 32'h0,          1, 1, 32'h3333_3333, 1'b0);
  endtask

  task automatic test_reset_mid_bus();
    @(negedge clk_i);
    req_i = 1'b1; addr_i = 32'h6000_0000; we_i = 1'b1; be_i = 4'hF; wdata_i = 32'h7777_7777;
    @(negedge clk_i);
    req_i = 1'b0;
    #1;
    tests_run++;
    if (wbm_cyc_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_mid_bus started: cyc=%b want 1", wbm_cyc_o);
    end
    @(negedge clk_i);
    rst_i = 1'b1; req_i = 1'b1;
    #1;
    tests_run++;
    if (gnt_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_bus gnt during reset: got %b want 0", gnt_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0; req_i = 1'b0;
    #1;
    tests_run++;
    if ({wbm_cyc_o, wbm_stb_o, rvalid_o, wbm_adr_o, wbm_dat_o} !== '0) begin
      tests_failed++;
      $display("FAIL reset_mid_bus after edge: cyc=%b stb=%b rvalid=%b adr=%h want 0",
               wbm_cyc_o, wbm_stb_o, rvalid_o, wbm_adr_o);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      wbm_ack_i = (i == 0);
      #1;
      tests_run++;
      if ({rvalid_o, wbm_cyc_o} !== 2'b00) begin
        tests_failed++;
        $display("FAIL reset_mid_bus spurious cycle %0d: rvalid=%b cyc=%b want 00", i, rvalid_o, wbm_cyc_o);
      end
    end
    wbm_ack_i = 1'b0;
    run_txn("after_reset", 32'h6000_0004, 1'b0, 4'b1111, 32'h0, 3, 0, 32'h8888_9999, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] a, d, rd;
    logic        w;
    logic [3:0]  b;
    int          rc, kind;
    bit          hold;
    for (int t = 0; t < 24; t++) begin
      a    = $urandom;
      d    = $urandom;
      rd   = $urandom;
      w    = 1'($urandom_range(0, 1));
      b    = 4'($urandom_range(0, 15));
      rc   = $urandom_range(1, 6);
      kind = $urandom_range(0, 2);
      hold = (t != 23) && ($urandom_range(0, 1) == 1);
      run_txn($sformatf("random_%0d", t), a, w, b, d, rc, kind, rd, hold);
    end
  endtask

  initial begin
    rst_i = 1'b1; req_i = 1'b0; addr_i = '0; we_i = 1'b0; be_i = '0; wdata_i = '0;
    wbm_dat_i = '0; wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
    test_reset();
    test_stray_ack();
    test_read_zero_wait();
    test_write_wait();
    test_ack_err_same();
    test_timeout();
    test_back_to_back();
    test_reset_mid_bus();
    test_random();
    repeat (2) @(negedge clk_i);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule : tb_obi_wb_bridge
